bram_stats_counter: RTL and testbench
=====================================

Name: bram_stats_counter

Overview:
- Read-modify-write front end for a simple dual-port block RAM with 1-cycle registered read and write-first same-address bypass. Used as a per-flow / per-entry statistics counter.
- Accepts increment requests on a valid/ready stream, plus single-outstanding host register reads with optional clear-on-read.
- Zero-initialises the RAM after reset.
- Handles all read-after-write hazards, so back-to-back updates to one entry are exact.

Parameters:
ADDR_WIDTH, 8, RAM address width; 2**ADDR_WIDTH counters.
CNT_WIDTH, 64, counter width; equals the RAM DATA_WIDTH.
INC_WIDTH, 16, increment width; zero-extended to CNT_WIDTH.

Ports:
CLK  in  1  single clock
RESETN  in  1  asynchronous active-low reset
INC_VALID  in  1  increment request valid
INC_READY  out  1  increment request accepted when VALID&READY
INC_ADDR  in  ADDR_WIDTH  counter index
INC_VAL  in  INC_WIDTH  amount to add
HOST_RD_REQ  in  1  one-cycle host read pulse
HOST_RD_ADDR  in  ADDR_WIDTH  host read index
HOST_RD_CLR  in  1  clear counter after read (sampled with REQ)
HOST_RD_ACK  out  1  one-cycle pulse, HOST_RD_DATA valid
HOST_RD_DATA  out  CNT_WIDTH  counter value before any clear
INIT_DONE  out  1  high once zero-initialisation is complete
BRAM_WR  out  1  RAM write enable
BRAM_ADDR_WR  out  ADDR_WIDTH  RAM write address
BRAM_DIN  out  CNT_WIDTH  RAM write data
BRAM_RD  out  1  RAM read enable
BRAM_ADDR_RD  out  ADDR_WIDTH  RAM read address
BRAM_DOUT  in  CNT_WIDTH  RAM read data, valid 1 cycle after BRAM_RD

Behaviour:
- Reset values: INC_READY=0, INIT_DONE=0, HOST_RD_ACK=0, HOST_RD_DATA=0, BRAM_WR=0, BRAM_RD=0, all addresses=0, BRAM_DIN=0.
- All pipeline valids, the host-pending flag and the FSM clear asynchronously. RAM contents are not reset.
- FSM states:
  - INIT: BRAM_WR=1, BRAM_DIN=0, BRAM_ADDR_WR = init counter 0..2**ADDR_WIDTH-1, one address per cycle. After the last address, go to RUN and set INIT_DONE=1 on the next cycle.
  - RUN: normal operation. Never returns to INIT except via RESETN.
- Host request latch: HOST_RD_REQ sets host_pending (captures addr and clr) in any state.
  - Host guarantees no new REQ until ACK.
  - A REQ during INIT is held and serviced in RUN.
- Issue slot (RUN only):
  - Host priority: if host_pending, issue a host op and clear host_pending. INC_READY=0 in that cycle.
  - Otherwise INC_READY=1, and INC_VALID&INC_READY issues an increment.
  - INC_READY is combinational: INIT_DONE & ~host_pending.
- Issue drives BRAM_RD=1 and BRAM_ADDR_RD combinationally. Op kinds are INC, RD and RDCLR.
- Stage P1 (issue+1): BRAM_DOUT is valid.
  - base = (P2.valid & P2.addr==P1.addr) ? P2.sum : BRAM_DOUT.
  - This forwarding covers back-to-back ops to the same address.
  - sum = INC: base+zext(INC_VAL), modulo 2**CNT_WIDTH (wrap, no saturation); RD: base; RDCLR: 0.
- Stage P2 (issue+2): BRAM_WR=P2.valid, BRAM_ADDR_WR=P2.addr, BRAM_DIN=P2.sum.
  - For host ops: HOST_RD_ACK=1 and HOST_RD_DATA=P2.base (the pre-clear value). HOST_RD_DATA holds until the next ACK.
- Gap-1 hazard: a read issued in the same cycle as a P2 write to the same address is resolved by the RAM's write-first bypass. No extra logic is needed.
- Gap of 2 or more cycles: the RAM already holds the updated value.
- Throughput: 1 op/cycle sustained. Increment latency is 2 cycles to write. Host read latency is 2 cycles from issue.
- Simultaneous INC_VALID and host_pending: the host wins and the INC waits (INC_VALID held, per handshake rules).
- Reset mid-operation: in-flight ops are lost. INIT re-zeroes all entries and a pending host read is dropped (no ACK).

Test Plan:
- Reset release, ADDR_WIDTH=8 -> 256 consecutive BRAM_WR cycles with DIN=0, addr 0..255. INIT_DONE=1 on cycle 257. INC_READY=0 throughout INIT.
- INC addr 5 val 10, then host RD addr 5 -> ACK 2 cycles after issue, DATA=10.
- Back-to-back INC addr 7 val 1,2,3 on consecutive cycles, then RD -> DATA=6. Repeat with 1-cycle gaps -> DATA=6.
- Set addr 9 to 42 via INCs, then RDCLR addr 9 -> DATA=42; a following RD addr 9 -> DATA=0. An INC issued the cycle after RDCLR gives a result equal to that INC value.
- Counter at 2**64-1, INC val 2 -> subsequent read returns 1 (wrap).
- HOST_RD_REQ while INC_VALID held high -> INC_READY=0 for exactly one cycle; no INC is lost; ACK correct.
- RESETN asserted mid-stream -> outputs return to reset values immediately; INIT restarts from address 0.

Source files
------------

// File: rtl/bram_stats_counter.sv
// Read-modify-write statistics counters over a simple dual-port block RAM.
// Zero-fills the RAM after reset, then merges increments and host reads.
module bram_stats_counter #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 64,
  parameter int INC_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  INC_VALID,
  output logic                  INC_READY,
  input  logic [ADDR_WIDTH-1:0] INC_ADDR,
  input  logic [INC_WIDTH-1:0]  INC_VAL,
  input  logic                  HOST_RD_REQ,
  input  logic [ADDR_WIDTH-1:0] HOST_RD_ADDR,
  input  logic                  HOST_RD_CLR,
  output logic                  HOST_RD_ACK,
  output logic [CNT_WIDTH-1:0]  HOST_RD_DATA,
  output logic                  INIT_DONE,
  output logic                  BRAM_WR,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR_WR,
  output logic [CNT_WIDTH-1:0]  BRAM_DIN,
  output logic                  BRAM_RD,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR_RD,
  input  logic [CNT_WIDTH-1:0]  BRAM_DOUT
);

  typedef enum logic [1:0] {
    OP_INC,
    OP_RD,
    OP_RDCLR
  } op_e;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic                  valid;
    op_e                   op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [INC_WIDTH-1:0]  val;
  } p1_t;

  typedef struct packed {
    logic                  valid;
    logic                  host;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  sum;
  } p2_t;

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_done_q;
  logic                  init_last;
  logic                  host_pend_q;
  logic                  host_clr_q;
  logic [ADDR_WIDTH-1:0] host_addr_q;
  logic                  host_issue;
  logic                  inc_issue;
  p1_t                   p1_q;
  p2_t                   p2_q;
  logic [CNT_WIDTH-1:0]  base;
  logic [CNT_WIDTH-1:0]  sum;
  logic [CNT_WIDTH-1:0]  rd_data_q;

  assign init_last = (init_cnt_q == '1);

  // FSM next state: INIT walks every address once, RUN is terminal
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (init_last) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= ST_INIT;
    else         state_q <= state_d;
  end

  // Zero-fill address counter; done flag rises the cycle after INIT ends
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
      init_done_q <= (state_q == ST_RUN);
    end
  end

  // Single outstanding host request, held until it wins the issue slot
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      host_pend_q <= 1'b0;
      host_addr_q <= '0;
      host_clr_q  <= 1'b0;
    end else if (HOST_RD_REQ) begin
      host_pend_q <= 1'b1;
      host_addr_q <= HOST_RD_ADDR;
      host_clr_q  <= HOST_RD_CLR;
    end else if (host_issue) begin
      host_pend_q <= 1'b0;
    end
  end

  assign host_issue   = init_done_q & host_pend_q;
  assign INC_READY    = init_done_q & ~host_pend_q;
  assign inc_issue    = INC_VALID & INC_READY;
  assign BRAM_RD      = host_issue | inc_issue;
  assign BRAM_ADDR_RD = host_issue ? host_addr_q :
                        inc_issue  ? INC_ADDR    : '0;

  // P1: the op whose RAM read data arrives this cycle
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      p1_q <= '0;
    end else begin
      p1_q.valid <= BRAM_RD;
      p1_q.op    <= !host_issue ? OP_INC   :
                    host_clr_q  ? OP_RDCLR : OP_RD;
      p1_q.addr  <= BRAM_ADDR_RD;
      p1_q.val   <= INC_VAL;
    end
  end

  // P1 merge: take the in-flight P2 result when it targets the same entry
  always_comb begin
    base = BRAM_DOUT;
    if (p2_q.valid && (p2_q.addr == p1_q.addr)) base = p2_q.sum;
    sum = base;
    unique case (p1_q.op)
      OP_INC:   sum = base + {{(CNT_WIDTH-INC_WIDTH){1'b0}}, p1_q.val};
      OP_RD:    sum = base;
      OP_RDCLR: sum = '0;
      default:  sum = base;
    endcase
  end

  // P2: write-back stage, also carries the zero-fill writes during INIT
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      p2_q <= '0;
    end else if (state_q == ST_INIT) begin
      p2_q.valid <= 1'b1;
      p2_q.host  <= 1'b0;
      p2_q.addr  <= init_cnt_q;
      p2_q.sum   <= '0;
    end else begin
      p2_q.valid <= p1_q.valid;
      p2_q.host  <= p1_q.valid && (p1_q.op != OP_INC);
      p2_q.addr  <= p1_q.addr;
      p2_q.sum   <= sum;
    end
  end

  // Host read data keeps the pre-clear value until the next host op
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rd_data_q <= '0;
    end else if (p1_q.valid && (p1_q.op != OP_INC)) begin
      rd_data_q <= base;
    end
  end

  assign BRAM_WR      = p2_q.valid;
  assign BRAM_ADDR_WR = p2_q.addr;
  assign BRAM_DIN     = p2_q.sum;
  assign HOST_RD_ACK  = p2_q.valid & p2_q.host;
  assign HOST_RD_DATA = rd_data_q;
  assign INIT_DONE    = init_done_q;

endmodule

// File: tb/tb_bram_stats_counter.sv
// Bench for bram_stats_counter: write-first RAM model, counter-array
// reference model, per-cycle compare and directed plus random traffic.
module tb_bram_stats_counter;

  localparam int AW = 8;
  localparam int CW = 64;
  localparam int IW = 16;
  localparam int N  = 1 << AW;

  logic          CLK;
  logic          RESETN;
  logic          INC_VALID;
  logic          INC_READY;
  logic [AW-1:0] INC_ADDR;
  logic [IW-1:0] INC_VAL;
  logic          HOST_RD_REQ;
  logic [AW-1:0] HOST_RD_ADDR;
  logic          HOST_RD_CLR;
  logic          HOST_RD_ACK;
  logic [CW-1:0] HOST_RD_DATA;
  logic          INIT_DONE;
  logic          BRAM_WR;
  logic [AW-1:0] BRAM_ADDR_WR;
  logic [CW-1:0] BRAM_DIN;
  logic          BRAM_RD;
  logic [AW-1:0] BRAM_ADDR_RD;
  logic [CW-1:0] BRAM_DOUT;

  bram_stats_counter #(
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW),
    .INC_WIDTH (IW)
  ) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .INC_VALID   (INC_VALID),
    .INC_READY   (INC_READY),
    .INC_ADDR    (INC_ADDR),
    .INC_VAL     (INC_VAL),
    .HOST_RD_REQ (HOST_RD_REQ),
    .HOST_RD_ADDR(HOST_RD_ADDR),
    .HOST_RD_CLR (HOST_RD_CLR),
    .HOST_RD_ACK (HOST_RD_ACK),
    .HOST_RD_DATA(HOST_RD_DATA),
    .INIT_DONE   (INIT_DONE),
    .BRAM_WR     (BRAM_WR),
    .BRAM_ADDR_WR(BRAM_ADDR_WR),
    .BRAM_DIN    (BRAM_DIN),
    .BRAM_RD     (BRAM_RD),
    .BRAM_ADDR_RD(BRAM_ADDR_RD),
    .BRAM_DOUT   (BRAM_DOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Block RAM: 1-cycle read, write-first on same address.
  // Contents are scrambled while reset is held.
  logic [CW-1:0] mem [N];
  logic          poke_en   = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [CW-1:0] poke_data = '0;

  initial BRAM_DOUT = '0;

  always @(posedge CLK) begin
    if (!RESETN)
      mem[AW'($urandom_range(0, N-1))] <= {$urandom(), $urandom()};
    else if (poke_en)
      mem[poke_addr] <= poke_data;
    if (BRAM_WR) mem[BRAM_ADDR_WR] <= BRAM_DIN;
    if (BRAM_RD)
      BRAM_DOUT <= (BRAM_WR && BRAM_ADDR_WR == BRAM_ADDR_RD) ?
                   BRAM_DIN : mem[BRAM_ADDR_RD];
  end

  // Reference model: one counter per entry, ops applied in issue order
  typedef struct {
    int            due;
    logic [CW-1:0] v;
  } ack_t;

  logic [CW-1:0] model [N];
  ack_t          aq [$];
  int            edge_cnt = 0;
  bit            pend     = 0;
  logic [AW-1:0] pa       = '0;
  bit            pc       = 0;
  logic [CW-1:0] last_d   = '0;
  int            acc_cnt  = 0;
  int            ack_cnt  = 0;
  logic [CW-1:0] ack_data = '0;

  task automatic model_clear();
    for (int i = 0; i < N; i++) model[i] = '0;
    aq.delete();
    pend   = 0;
    last_d = '0;
  endtask

  initial begin
    ack_t e;
    int   n;
    model_clear();
    forever begin
      @(posedge CLK);
      if (!RESETN) begin
        edge_cnt = 0;
      end else begin
        edge_cnt++;
        n = edge_cnt;
        if (n >= N + 2) begin
          if (pend) begin
            e.due = n + 1;
            e.v   = model[pa];
            aq.push_back(e);
            if (pc) model[pa] = '0;
            pend = 0;
          end else if (INC_VALID) begin
            model[INC_ADDR] = model[INC_ADDR] + CW'(INC_VAL);
            acc_cnt++;
          end
        end
        if (poke_en) model[poke_addr] = poke_data;
        if (HOST_RD_REQ) begin
          pend = 1;
          pa   = HOST_RD_ADDR;
          pc   = HOST_RD_CLR;
        end
      end
      @(negedge CLK);
      if (!RESETN) begin
        chk("reset_vals",
            {INC_READY, INIT_DONE, HOST_RD_ACK, BRAM_WR, BRAM_RD,
             BRAM_ADDR_WR, BRAM_ADDR_RD, BRAM_DIN, HOST_RD_DATA},
            '0);
        model_clear();
      end else begin
        n = edge_cnt;
        chk("init_done", INIT_DONE, n >= N + 1);
        chk("inc_ready", INC_READY, (n >= N + 1) && !pend);
        if (n >= 1 && n <= N)
          chk("init_write", {BRAM_WR, BRAM_RD, BRAM_ADDR_WR, BRAM_DIN},
              {1'b1, 1'b0, AW'(n - 1), CW'(0)});
        if (aq.size() > 0 && aq[0].due == n) begin
          chk("ack", HOST_RD_ACK, 1'b1);
          chk("ack_data", HOST_RD_DATA, aq[0].v);
          last_d   = aq[0].v;
          ack_data = HOST_RD_DATA;
          ack_cnt++;
          void'(aq.pop_front());
        end else begin
          chk("no_ack", HOST_RD_ACK, 1'b0);
          chk("data_hold", HOST_RD_DATA, last_d);
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_inc(input logic [AW-1:0] a,
                        input logic [IW-1:0] v,
                        output int w);
    int c0;
    c0 = acc_cnt;
    w  = 0;
    INC_VALID = 1'b1;
    INC_ADDR  = a;
    INC_VAL   = v;
    while (acc_cnt == c0 && w < 40) begin
      step();
      w++;
    end
    chk("inc_accept", acc_cnt != c0, 1'b1);
    INC_VALID = 1'b0;
  endtask

  task automatic host_req(input logic [AW-1:0] a,
                          input logic clr,
                          output int c0);
    c0 = ack_cnt;
    HOST_RD_REQ  = 1'b1;
    HOST_RD_ADDR = a;
    HOST_RD_CLR  = clr;
    step();
    HOST_RD_REQ = 1'b0;
  endtask

  task automatic host_wait(input int c0, output logic [CW-1:0] d);
    int w;
    w = 0;
    while (ack_cnt == c0 && w < 40) begin
      step();
      w++;
    end
    chk("ack_seen", ack_cnt != c0, 1'b1);
    d = ack_data;
  endtask

  task automatic host_read(input logic [AW-1:0] a,
                           input logic clr,
                           output logic [CW-1:0] d);
    int c0;
    host_req(a, clr, c0);
    host_wait(c0, d);
  endtask

  initial begin
    logic [CW-1:0] d;
    int            w;
    int            c0;
    int            wr;
    int            steps;
    int            acc_seen;

    RESETN       = 1'b0;
    INC_VALID    = 1'b0;
    INC_ADDR     = '0;
    INC_VAL      = '0;
    HOST_RD_REQ  = 1'b0;
    HOST_RD_ADDR = '0;
    HOST_RD_CLR  = 1'b0;
    repeat (5) step();
    RESETN = 1'b1;

    wr    = 0;
    steps = 0;
    while (steps < 400) begin
      step();
      steps++;
      if (INIT_DONE) break;
      if (BRAM_WR) wr++;
    end
    chk("init_wr_cycles", wr, N);
    chk("init_done_cycle", steps, N + 1);

    do_inc(5, 10, w);
    host_read(5, 1'b0, d);
    chk("inc_then_rd", d, 10);

    do_inc(7, 1, w);
    do_inc(7, 2, w);
    do_inc(7, 3, w);
    host_read(7, 1'b0, d);
    chk("b2b_sum", d, 6);

    do_inc(8, 1, w);
    step();
    do_inc(8, 2, w);
    step();
    do_inc(8, 3, w);
    host_read(8, 1'b0, d);
    chk("gap1_sum", d, 6);

    do_inc(9, 40, w);
    do_inc(9, 2, w);
    host_read(9, 1'b1, d);
    chk("rdclr_val", d, 42);
    host_read(9, 1'b0, d);
    chk("after_clr", d, 0);

    do_inc(9, 100, w);
    host_req(9, 1'b1, c0);
    do_inc(9, 55, w);
    chk("host_wins_wait", w, 2);
    host_wait(c0, d);
    chk("rdclr_b2b_val", d, 100);
    host_read(9, 1'b0, d);
    chk("inc_after_clr", d, 55);

    step();
    poke_en   = 1'b1;
    poke_addr = 20;
    poke_data = '1;
    step();
    poke_en = 1'b0;
    step();
    do_inc(20, 2, w);
    host_read(20, 1'b0, d);
    chk("wrap", d, 1);

    acc_seen = acc_cnt;
    for (int i = 0; i < 1500; i++) begin
      step();
      HOST_RD_REQ = 1'b0;
      if (i == 700) begin
        @(posedge CLK);
        #2;
        RESETN      = 1'b0;
        INC_VALID   = 1'b0;
        #1;
        chk("reset_now", {INC_READY, INIT_DONE, HOST_RD_ACK,
                          BRAM_WR, BRAM_ADDR_WR, BRAM_DIN}, '0);
        repeat (3) step();
        RESETN   = 1'b1;
        acc_seen = acc_cnt;
        continue;
      end
      if (acc_cnt != acc_seen) begin
        acc_seen  = acc_cnt;
        INC_VALID = 1'b0;
      end
      if (!INC_VALID && ($urandom_range(0, 3) != 0)) begin
        INC_VALID = 1'b1;
        INC_ADDR  = ($urandom_range(0, 9) == 0) ?
                    AW'($urandom()) : AW'($urandom_range(0, 7));
        INC_VAL   = ($urandom_range(0, 1) == 0) ?
                    IW'($urandom()) : IW'($urandom_range(0, 3));
      end
      if (!pend && aq.size() == 0 && ($urandom_range(0, 5) == 0)) begin
        HOST_RD_REQ  = 1'b1;
        HOST_RD_ADDR = AW'($urandom_range(0, 7));
        HOST_RD_CLR  = ($urandom_range(0, 2) == 0);
      end
    end
    HOST_RD_REQ = 1'b0;
    while (INC_VALID && acc_cnt == acc_seen && steps < 2000) begin
      step();
      steps++;
    end
    INC_VALID = 1'b0;
    repeat (20) step();
    chk("drained", (aq.size() == 0) && !pend, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
